// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types for the spike AER encoder
package snn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EOT  = 2'd2
   } aer_state_t;

   // Widest supported event address; encoders narrower than this leave upper bits zero.
   localparam int AER_ADDR_W_MAX = 16;

   typedef struct packed {
      logic [AER_ADDR_W_MAX-1:0] addr;
      logic                      eot;
   } aer_event_t;

endpackage

// File: rtl/spike_prio_enc.sv
// rtl/spike_prio_enc.sv - lowest-set-bit index search over a spike vector
module spike_prio_enc #(
   parameter int N = 16
) (
   input  logic [N-1:0]         vec,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);
   localparam int AW = $clog2(N);

   // Scanning downward lets the lowest set bit win the last assignment.
   always_comb begin
      idx = '0;
      any = |vec;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) idx = AW'(i);
      end
   end

endmodule

// File: rtl/spike_aer_encoder.sv
// rtl/spike_aer_encoder.sv - serialises a per-timestep spike vector into AER events
module spike_aer_encoder
   import snn_pkg::*;
#(
   parameter int N     = 16,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         spike_in,
   input  logic                 tick,
   output logic                 tick_ready,
   output logic [$clog2(N)-1:0] aer_addr,
   output logic                 aer_eot,
   output logic                 aer_valid,
   input  logic                 aer_ready,
   output logic                 overrun,
   output logic [CNT_W-1:0]     overrun_count
);
   localparam int AW = $clog2(N);

   aer_state_t    state, state_n;
   logic [N-1:0]  pending, pending_n;
   logic [AW-1:0] scan_idx;
   logic          scan_any;
   logic          drop;
   aer_event_t    ev;
   logic          unused_ev_bits;

   spike_prio_enc #(.N(N)) u_prio_enc (
      .vec (pending),
      .idx (scan_idx),
      .any (scan_any)
   );

   always_comb begin
      state_n   = state;
      pending_n = pending;
      ev        = '0;
      aer_valid = 1'b0;
      case (state)
         IDLE: begin
            if (tick) begin
               pending_n = spike_in;
               state_n   = (|spike_in) ? SCAN : EOT;
            end
         end
         SCAN: begin
            aer_valid = 1'b1;
            ev.addr   = AER_ADDR_W_MAX'(scan_idx);
            // An empty pending vector here can only be defensive; fall through to EOT.
            if (!scan_any) begin
               state_n = EOT;
            end else if (aer_ready) begin
               pending_n = pending & ~(N'(1) << scan_idx);
               if (pending_n == '0) state_n = EOT;
            end
         end
         EOT: begin
            aer_valid = 1'b1;
            ev.eot    = 1'b1;
            if (aer_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign drop           = tick && (state != IDLE);
   assign tick_ready     = (state == IDLE);
   assign aer_addr       = ev.addr[AW-1:0];
   assign aer_eot        = ev.eot;
   assign unused_ev_bits = ^ev.addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         pending       <= '0;
         overrun       <= 1'b0;
         overrun_count <= '0;
      end else begin
         state   <= state_n;
         pending <= pending_n;
         if (drop) begin
            overrun <= 1'b1;
            if (overrun_count != '1) overrun_count <= overrun_count + CNT_W'(1);
         end
      end
   end

endmodule
